// File: rtl/dm_pkg.sv
// Shared encodings for the data-memory controller: access types and FSM states.
package dm_pkg;

  localparam logic [2:0] DM_W  = 3'b000;
  localparam logic [2:0] DM_H  = 3'b001;
  localparam logic [2:0] DM_HU = 3'b010;
  localparam logic [2:0] DM_B  = 3'b011;
  localparam logic [2:0] DM_BU = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } dm_state_e;

endpackage

// File: rtl/dm_lane_align.sv
// Byte-lane steering for one access: store byte-enables and replicated data,
// load lane extraction with sign/zero extension, and alignment/type error.
module dm_lane_align
  import dm_pkg::*;
(
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  dmtype_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  logic [31:0] shifted;

  always_comb begin
    be_o    = 4'b0000;
    wdata_o = 32'h0;
    rdata_o = 32'h0;
    err_o   = 1'b0;
    shifted = rword_i >> {addr_lo_i, 3'b000};
    case (dmtype_i)
      DM_W: begin
        err_o   = (addr_lo_i != 2'b00);
        be_o    = 4'b1111;
        wdata_o = wdata_i;
        rdata_o = shifted;
      end
      DM_H, DM_HU: begin
        err_o   = addr_lo_i[0];
        be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = {{16{(dmtype_i == DM_H) & shifted[15]}}, shifted[15:0]};
      end
      DM_B, DM_BU: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {{24{(dmtype_i == DM_B) & shifted[7]}}, shifted[7:0]};
      end
      default: err_o = 1'b1;
    endcase
    // A rejected access must never touch the array.
    if (err_o) be_o = 4'b0000;
  end

endmodule

// File: rtl/dm_ctrl.sv
// Data-memory controller: single-outstanding request port with configurable
// load latency, byte/half/word access, error reporting and a debug read port.
module dm_ctrl
  import dm_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 128,
  parameter int unsigned RD_LAT      = 1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  input  logic [2:0]       req_dmtype,
  output logic             rsp_valid,
  output logic [31:0]      rsp_rdata,
  output logic             rsp_err,
  output logic [CNT_W-1:0] err_cnt,
  input  logic [31:0]      dbg_addr,
  output logic [31:0]      dbg_rdata,
  output logic [1:0]       dbg_state
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  // WAIT holds RD_LAT-2 extra cycles so the response lands RD_LAT cycles after accept.
  localparam logic [1:0] WAIT_INIT = (RD_LAT > 1) ? 2'(RD_LAT - 2) : 2'd0;

  logic [31:0] mem_q [0:DEPTH_WORDS-1];

  dm_state_e        state_q, state_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             we_q, err_q;
  logic [2:0]       dmtype_q;
  logic [1:0]       addr_lo_q;
  logic [AW-1:0]    idx_q;
  logic [CNT_W-1:0] err_cnt_q;

  logic [29:0]   req_word, dbg_word;
  logic [AW-1:0] req_idx;
  logic          req_in_range, req_err, accept;
  logic [1:0]    al_addr;
  logic [2:0]    al_type;
  logic [3:0]    al_be;
  logic [31:0]   al_wdata, al_rdata, rword;
  logic          al_err;
  logic          dbg_unused;

  assign req_word     = req_addr[31:2];
  assign req_idx      = req_word[AW-1:0];
  assign req_in_range = (req_word < 30'(DEPTH_WORDS));

  // Handshake: a request is taken on a rising edge where req_valid and
  // req_ready are both high; ready is high only in IDLE, and each accepted
  // request produces exactly one rsp_valid pulse with no backpressure.
  assign req_ready = (state_q == S_IDLE);
  assign accept    = req_valid & req_ready;

  // In IDLE the aligner serves the incoming store; afterwards it serves the latched load.
  assign al_addr = (state_q == S_IDLE) ? req_addr[1:0] : addr_lo_q;
  assign al_type = (state_q == S_IDLE) ? req_dmtype    : dmtype_q;
  assign rword   = mem_q[idx_q];
  assign req_err = al_err | ~req_in_range;

  dm_lane_align u_align (
    .addr_lo_i (al_addr),
    .dmtype_i  (al_type),
    .wdata_i   (req_wdata),
    .rword_i   (rword),
    .be_o      (al_be),
    .wdata_o   (al_wdata),
    .rdata_o   (al_rdata),
    .err_o     (al_err)
  );

  always_ff @(posedge clk) begin
    if (accept && req_we && !req_err) begin
      for (int b = 0; b < 4; b++) begin
        if (al_be[b]) mem_q[req_idx][8*b +: 8] <= al_wdata[8*b +: 8];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (req_we || req_err || (RD_LAT <= 32'd1)) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 2'd0) state_d = S_RESP;
        else               cnt_d   = cnt_q - 2'd1;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 2'd0;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      dmtype_q  <= DM_W;
      addr_lo_q <= 2'b00;
      idx_q     <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q      <= req_we;
        err_q     <= req_err;
        dmtype_q  <= req_dmtype;
        addr_lo_q <= req_addr[1:0];
        idx_q     <= req_idx;
      end
      if ((state_q == S_RESP) && err_q && (err_cnt_q != {CNT_W{1'b1}})) begin
        err_cnt_q <= err_cnt_q + 1'b1;
      end
    end
  end

  assign rsp_valid = (state_q == S_RESP);
  assign rsp_err   = rsp_valid & err_q;
  assign rsp_rdata = (rsp_valid && !err_q && !we_q) ? al_rdata : 32'h0;
  assign err_cnt   = err_cnt_q;
  assign dbg_state = state_q;

  assign dbg_word   = dbg_addr[31:2];
  assign dbg_unused = ^dbg_addr[1:0];
  assign dbg_rdata  = (dbg_word < 30'(DEPTH_WORDS)) ? mem_q[dbg_word[AW-1:0]] : 32'h0;

endmodule

// File: tb/tb_dm_ctrl.sv
// Directed bench for dm_ctrl: three instances (RD_LAT 1/3/4, the last with a
// 2-bit error counter) share one request stream and are checked side by side.
module tb_dm_ctrl;
  import dm_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we;
  logic [31:0] req_addr, req_wdata, dbg_addr;
  logic [2:0]  req_dmtype;

  logic        req_ready [3];
  logic        rsp_valid [3];
  logic        rsp_err   [3];
  logic [31:0] rsp_rdata [3];
  logic [31:0] dbg_rdata [3];
  logic [1:0]  dbg_state [3];
  logic [15:0] err_cnt0, err_cnt1;
  logic [1:0]  err_cnt2;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] got_rdata [3];
  logic        got_err   [3];
  int          got_lat   [3];

  always #5 clk = ~clk;

  dm_ctrl #(.DEPTH_WORDS(128), .RD_LAT(1), .CNT_W(16)) u_dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready[0]),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_dmtype(req_dmtype),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]),
    .err_cnt(err_cnt0), .dbg_addr(dbg_addr), .dbg_rdata(dbg_rdata[0]), .dbg_state(dbg_state[0]));

  dm_ctrl #(.DEPTH_WORDS(128), .RD_LAT(3), .CNT_W(16)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready[1]),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_dmtype(req_dmtype),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]),
    .err_cnt(err_cnt1), .dbg_addr(dbg_addr), .dbg_rdata(dbg_rdata[1]), .dbg_state(dbg_state[1]));

  dm_ctrl #(.DEPTH_WORDS(128), .RD_LAT(4), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready[2]),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_dmtype(req_dmtype),
    .rsp_valid(rsp_valid[2]), .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2]),
    .err_cnt(err_cnt2), .dbg_addr(dbg_addr), .dbg_rdata(dbg_rdata[2]), .dbg_state(dbg_state[2]));

  function automatic int load_lat(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 3 : 4);
  endfunction

  // One request, held valid for the accept edge only; collects each instance's response.
  task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [2:0] t);
    bit seen [3];
    @(negedge clk);
    req_we = we; req_addr = addr; req_wdata = wdata; req_dmtype = t; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      seen[i] = 1'b0; got_lat[i] = -1; got_rdata[i] = 32'hDEAD_BEEF; got_err[i] = 1'bx;
    end
    for (int cyc = 1; cyc <= 8; cyc++) begin
      for (int i = 0; i < 3; i++) begin
        if (!seen[i] && rsp_valid[i]) begin
          seen[i] = 1'b1; got_lat[i] = cyc; got_rdata[i] = rsp_rdata[i]; got_err[i] = rsp_err[i];
        end
      end
      if (seen[0] && seen[1] && seen[2]) break;
      @(posedge clk); #1;
    end
    checks++;
    if (!(seen[0] && seen[1] && seen[2])) begin
      errors++;
      $display("FAIL rsp_timeout addr=%h seen=%0d%0d%0d required=111", addr, seen[0], seen[1], seen[2]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    req_dmtype = DM_W; dbg_addr = 32'h10;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (req_ready[i] !== 1'b1 || rsp_valid[i] !== 1'b0 || rsp_err[i] !== 1'b0 ||
          rsp_rdata[i] !== 32'h0 || dbg_state[i] !== 2'd0) begin
        errors++;
        $display("FAIL reset_outputs inst%0d ready=%b valid=%b err=%b rdata=%h state=%0d required 1 0 0 0 0",
                 i, req_ready[i], rsp_valid[i], rsp_err[i], rsp_rdata[i], dbg_state[i]);
      end
    end
    checks++;
    if (err_cnt0 !== 16'd0 || err_cnt1 !== 16'd0 || err_cnt2 !== 2'd0) begin
      errors++;
      $display("FAIL reset_err_cnt got %0d %0d %0d required 0 0 0", err_cnt0, err_cnt1, err_cnt2);
    end
    rst = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    bit late_rsp = 1'b0;
    @(negedge clk);
    req_we = 1'b0; req_addr = 32'h0; req_dmtype = DM_W; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checks++;
    if (dbg_state[2] !== 2'd0) begin
      errors++;
      $display("FAIL mid_wait_state got %0d required 0", dbg_state[2]);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      @(posedge clk); #1;
      if (rsp_valid[1] || rsp_valid[2]) late_rsp = 1'b1;
      if (cyc == 1) begin
        checks++;
        if (req_ready[0] !== 1'b1 || req_ready[1] !== 1'b1 || req_ready[2] !== 1'b1) begin
          errors++;
          $display("FAIL mid_wait_ready got %b%b%b required 111", req_ready[0], req_ready[1], req_ready[2]);
        end
      end
    end
    checks++;
    if (late_rsp !== 1'b0) begin
      errors++;
      $display("FAIL mid_wait_dropped got rsp_valid=1 required 0");
    end
    checks++;
    if (err_cnt2 !== 2'd0) begin
      errors++;
      $display("FAIL mid_wait_err_cnt got %0d required 0", err_cnt2);
    end
  endtask

  task automatic test_word();
    do_txn(1'b1, 32'h0, 32'h0, DM_W);
    do_txn(1'b1, 32'h10, 32'h8765_4321, DM_W);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (got_lat[i] !== 1 || got_err[i] !== 1'b0 || got_rdata[i] !== 32'h0) begin
        errors++;
        $display("FAIL sw_rsp inst%0d lat=%0d err=%b rdata=%h required 1 0 00000000",
                 i, got_lat[i], got_err[i], got_rdata[i]);
      end
    end
    do_txn(1'b0, 32'h10, 32'h0, DM_W);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (got_lat[i] !== load_lat(i) || got_err[i] !== 1'b0 || got_rdata[i] !== 32'h8765_4321) begin
        errors++;
        $display("FAIL lw_rsp inst%0d lat=%0d err=%b rdata=%h required %0d 0 87654321",
                 i, got_lat[i], got_err[i], got_rdata[i], load_lat(i));
      end
    end
  endtask

  // Shared by the byte and half tests: one store followed by a table of loads.
  task automatic test_subword(input logic [31:0] st_addr, input logic [31:0] st_data,
                              input logic [2:0] st_type, input logic [2:0] ld_type [5],
                              input logic [31:0] ld_addr [5], input logic [31:0] ld_exp [5]);
    do_txn(1'b1, st_addr, st_data, st_type);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (got_lat[i] !== 1 || got_err[i] !== 1'b0 || got_rdata[i] !== 32'h0) begin
        errors++;
        $display("FAIL sub_store @%h inst%0d lat=%0d err=%b rdata=%h required 1 0 0",
                 st_addr, i, got_lat[i], got_err[i], got_rdata[i]);
      end
    end
    for (int k = 0; k < 5; k++) begin
      do_txn(1'b0, ld_addr[k], 32'h0, ld_type[k]);
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got_lat[i] !== load_lat(i) || got_err[i] !== 1'b0 || got_rdata[i] !== ld_exp[k]) begin
          errors++;
          $display("FAIL sub_load t=%0d @%h inst%0d lat=%0d err=%b rdata=%h required %0d 0 %h",
                   ld_type[k], ld_addr[k], i, got_lat[i], got_err[i], got_rdata[i],
                   load_lat(i), ld_exp[k]);
        end
      end
    end
  endtask

  task automatic test_byte();
    logic [2:0]  t [5] = '{DM_B, DM_BU, DM_W, DM_BU, DM_B};
    logic [31:0] a [5] = '{32'h11, 32'h11, 32'h10, 32'h10, 32'h13};
    logic [31:0] e [5] = '{32'hFFFF_FFAB, 32'h0000_00AB, 32'h8765_AB21, 32'h0000_0021, 32'hFFFF_FF87};
    test_subword(32'h11, 32'h1234_56AB, DM_B, t, a, e);
  endtask

  task automatic test_half();
    logic [2:0]  t [5] = '{DM_H, DM_HU, DM_W, DM_HU, DM_B};
    logic [31:0] a [5] = '{32'h12, 32'h12, 32'h10, 32'h10, 32'h13};
    logic [31:0] e [5] = '{32'hFFFF_8001, 32'h0000_8001, 32'h8001_AB21, 32'h0000_AB21, 32'hFFFF_FF80};
    test_subword(32'h12, 32'hDEAD_8001, DM_H, t, a, e);
  endtask

  task automatic test_errors();
    logic        we [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] a  [5] = '{32'h13, 32'h11, 32'h10, 32'h200, 32'hFFFF_FFFC};
    logic [31:0] d  [5] = '{32'h0, 32'hFFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0};
    logic [2:0]  t  [5] = '{DM_W, DM_H, 3'b101, DM_W, DM_BU};
    logic [15:0] exp_cnt [5] = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5};
    logic [1:0]  exp_sat [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    for (int k = 0; k < 5; k++) begin
      do_txn(we[k], a[k], d[k], t[k]);
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got_lat[i] !== 1 || got_err[i] !== 1'b1 || got_rdata[i] !== 32'h0) begin
          errors++;
          $display("FAIL err_rsp case%0d inst%0d lat=%0d err=%b rdata=%h required 1 1 0",
                   k, i, got_lat[i], got_err[i], got_rdata[i]);
        end
      end
      checks++;
      if (err_cnt0 !== exp_cnt[k] || err_cnt1 !== exp_cnt[k] || err_cnt2 !== exp_sat[k]) begin
        errors++;
        $display("FAIL err_cnt case%0d got %0d %0d %0d required %0d %0d %0d",
                 k, err_cnt0, err_cnt1, err_cnt2, exp_cnt[k], exp_cnt[k], exp_sat[k]);
      end
    end
    do_txn(1'b0, 32'h10, 32'h0, DM_W);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (got_rdata[i] !== 32'h8001_AB21 || got_err[i] !== 1'b0) begin
        errors++;
        $display("FAIL err_mem_unchanged inst%0d rdata=%h err=%b required 8001ab21 0",
                 i, got_rdata[i], got_err[i]);
      end
    end
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      dbg_addr = (k == 0) ? 32'h200 : 32'h0;
      #1;
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (dbg_rdata[i] !== 32'h0) begin
          errors++;
          $display("FAIL dbg_read @%h inst%0d got %h required 00000000", dbg_addr, i, dbg_rdata[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic       exp_v [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic       exp_r [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    dbg_addr = 32'h10;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (dbg_rdata[i] !== 32'h8001_AB21) begin
        errors++;
        $display("FAIL dbg_before inst%0d got %h required 8001ab21", i, dbg_rdata[i]);
      end
    end
    req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'hCAFE_F00D; req_dmtype = DM_W; req_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (c == 2) req_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (rsp_valid[i] !== exp_v[c] || req_ready[i] !== exp_r[c]) begin
          errors++;
          $display("FAIL hold_valid cyc%0d inst%0d valid=%b ready=%b required %b %b",
                   c, i, rsp_valid[i], req_ready[i], exp_v[c], exp_r[c]);
        end
        if (c == 0) begin
          checks++;
          if (dbg_rdata[i] !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL dbg_after inst%0d got %h required cafef00d", i, dbg_rdata[i]);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_wait();
    test_word();
    test_byte();
    test_half();
    test_errors();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
